// File: rtl/bram_line_mover_if.sv
// Request, status and BRAM native-port signals of bram_line_mover.
// The slave side is the mover; the master side is its environment.
interface bram_line_mover_if #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 15
);
    localparam int WORDS = LINE_W / WORD_W;
    localparam int BYTES = WORD_W / 8;
    localparam int CNT_W = $clog2(WORDS) + 1;

    logic              i_trigger;
    logic              i_mode;
    logic [ADDR_W-1:0] i_base_addr;
    logic [CNT_W-1:0]  i_num_words;
    logic [LINE_W-1:0] i_wrdata;
    logic [LINE_W-1:0] o_rddata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_bram_en;
    logic [BYTES-1:0]  o_bram_we;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [WORD_W-1:0] o_bram_wrdata;
    logic [WORD_W-1:0] i_bram_rddata;

    modport slave (
        input  i_trigger, i_mode, i_base_addr, i_num_words, i_wrdata, i_bram_rddata,
        output o_rddata, o_busy, o_done, o_err,
        output o_bram_en, o_bram_we, o_bram_addr, o_bram_wrdata
    );

    modport master (
        output i_trigger, i_mode, i_base_addr, i_num_words, i_wrdata, i_bram_rddata,
        input  o_rddata, o_busy, o_done, o_err,
        input  o_bram_en, o_bram_we, o_bram_addr, o_bram_wrdata
    );
endinterface

// File: rtl/bram_line_mover.sv
// Moves one LINE_W cache line to or from a WORD_W BRAM port, one word per cycle,
// with programmable word count and a RD_LAT-deep read-return pipeline.
module bram_line_mover #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input logic              S_AXI_ACLK,
    input logic              S_AXI_ARESETN,
    bram_line_mover_if.slave bus
);
    localparam int WORDS = LINE_W / WORD_W;
    localparam int BYTES = WORD_W / 8;
    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [RD_LAT-1:0] OLDEST = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              trig_q;
    logic              start;
    logic              unaligned;
    logic              last_word;
    logic              younger_busy;
    logic [CNT_W-1:0]  n_eff;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  k_q;
    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] line_q;
    logic              err_q;
    logic [RD_LAT-1:0] vld_q;
    logic [IDX_W-1:0]  idx_q [RD_LAT];

    assign start        = bus.i_trigger & ~trig_q;
    assign unaligned    = (bus.i_base_addr & ADDR_W'(BYTES - 1)) != '0;
    assign n_eff        = (bus.i_num_words == '0 || bus.i_num_words > CNT_W'(WORDS))
                          ? CNT_W'(WORDS) : bus.i_num_words;
    assign last_word    = (k_q == n_q - CNT_W'(1));
    // Returns still in flight ahead of the oldest stage keep the drain going.
    assign younger_busy = (vld_q & ~OLDEST) != '0;

    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_done = (state_q == DONE);
    assign bus.o_err  = (state_q == DONE) && err_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d           = state_q;
        bus.o_bram_en     = 1'b0;
        bus.o_bram_we     = '0;
        bus.o_bram_addr   = '0;
        bus.o_bram_wrdata = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (unaligned)        state_d = DONE;
                    else if (bus.i_mode)  state_d = RD_ISSUE;
                    else                  state_d = WRITE;
                end
            end
            WRITE: begin
                bus.o_bram_en     = 1'b1;
                bus.o_bram_we     = '1;
                bus.o_bram_addr   = base_q + ADDR_W'(k_q) * ADDR_W'(BYTES);
                bus.o_bram_wrdata = line_q[k_q[IDX_W-1:0]*WORD_W +: WORD_W];
                if (last_word) state_d = DONE;
            end
            RD_ISSUE: begin
                bus.o_bram_en   = 1'b1;
                bus.o_bram_addr = base_q + ADDR_W'(k_q) * ADDR_W'(BYTES);
                if (last_word) state_d = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (!younger_busy) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= IDLE;
            trig_q       <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            base_q       <= '0;
            // NOTE: the line buffer is a flop array, not a RAM, so it takes the async reset.
            line_q       <= '0;
            err_q        <= 1'b0;
            bus.o_rddata <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= bus.i_trigger;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        line_q <= bus.i_wrdata;
                        base_q <= bus.i_base_addr;
                        n_q    <= n_eff;
                        k_q    <= '0;
                        err_q  <= unaligned;
                        if (bus.i_mode && !unaligned) bus.o_rddata <= '0;
                    end
                end
                WRITE, RD_ISSUE: k_q <= k_q + CNT_W'(1);
                default: ;
            endcase
            if (vld_q[RD_LAT-1])
                bus.o_rddata[idx_q[RD_LAT-1]*WORD_W +: WORD_W] <= bus.i_bram_rddata;
        end
    end

    // Read-return tracker: stage 0 is the youngest issue, stage RD_LAT-1 meets the data.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= (state_q == RD_ISSUE);
            idx_q[0] <= k_q[IDX_W-1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_bram_line_mover.sv
// Scoreboard bench for bram_line_mover: a reference model queues expected BRAM
// accesses and completions; a negedge monitor pops and compares them.
module tb_bram_line_mover;
    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 15;
    localparam int RD_LAT = 2;
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int MEM_N  = 1 << (ADDR_W - 2);

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        int                cyc;
    } acc_t;

    typedef struct {
        bit                err;
        int                cyc;
        logic [LINE_W-1:0] rd;
    } done_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    acc_t exp_acc[$];
    done_t exp_done[$];
    acc_t mon_a;
    done_t mon_d;

    logic [WORD_W-1:0] mem [MEM_N];
    logic [WORD_W-1:0] ref_mem [MEM_N];
    logic [WORD_W-1:0] rd_pipe [RD_LAT];
    logic [LINE_W-1:0] ref_rddata;
    bit                preloaded;

    bram_line_mover_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    bram_line_mover #(
        .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: synchronous write, RD_LAT-cycle read; address a initially holds a.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= WORD_W'(i * 4);
            preloaded <= 1'b1;
        end else if (bus.o_bram_en && bus.o_bram_we == '1) begin
            mem[bus.o_bram_addr[ADDR_W-1:2]] <= bus.o_bram_wrdata;
        end
        rd_pipe[0] <= (bus.o_bram_en && bus.o_bram_we == '0)
                      ? mem[bus.o_bram_addr[ADDR_W-1:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.i_bram_rddata = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every BRAM access and every completion against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_bram_en) begin
                if (exp_acc.size() == 0) begin
                    check("unexpected_en", 1, 0);
                end else begin
                    mon_a = exp_acc.pop_front();
                    check("acc_cycle", cyc, mon_a.cyc);
                    check("acc_addr", bus.o_bram_addr, mon_a.addr);
                    check("acc_we", bus.o_bram_we, mon_a.we ? 4'hF : 4'h0);
                    if (mon_a.we) check("acc_wrdata", bus.o_bram_wrdata, mon_a.data);
                end
            end else begin
                check("idle_port", {bus.o_bram_we, bus.o_bram_wrdata}, '0);
            end
            if (bus.o_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_cycle", cyc, mon_d.cyc);
                    check("done_err", bus.o_err, mon_d.err);
                    check("done_busy", bus.o_busy, 1);
                    check("rddata", bus.o_rddata, mon_d.rd);
                end
            end else if (bus.o_err) begin
                check("err_without_done", 1, 0);
            end
        end
    end

    // Reference model: derives the access list and result of one request from the rules.
    task automatic start_op(input bit mode, input logic [ADDR_W-1:0] base, input int nw,
                            input logic [LINE_W-1:0] line);
        int n;
        int t0;
        bit bad;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] rd;
        @(posedge clk); #1;
        bus.i_mode      = mode;
        bus.i_base_addr = base;
        bus.i_num_words = 5'(nw);
        bus.i_wrdata    = line;
        bus.i_trigger   = 1'b1;
        t0  = cyc;
        n   = (nw == 0 || nw > WORDS) ? WORDS : nw;
        bad = (base % 4) != 0;
        rd  = '0;
        if (bad) begin
            exp_done.push_back('{err: 1'b1, cyc: t0 + 1, rd: ref_rddata});
        end else begin
            for (int k = 0; k < n; k++) begin
                a = base + ADDR_W'(4 * k);
                if (!mode) begin
                    exp_acc.push_back('{we: 1'b1, addr: a, data: line[k*WORD_W +: WORD_W],
                                        cyc: t0 + 1 + k});
                    ref_mem[a / 4] = line[k*WORD_W +: WORD_W];
                end else begin
                    exp_acc.push_back('{we: 1'b0, addr: a, data: '0, cyc: t0 + 1 + k});
                    rd[k*WORD_W +: WORD_W] = ref_mem[a / 4];
                end
            end
            if (mode) ref_rddata = rd;
            exp_done.push_back('{err: 1'b0, cyc: mode ? t0 + n + RD_LAT + 1 : t0 + n + 1,
                                 rd: ref_rddata});
        end
        @(posedge clk); #1;
        bus.i_trigger = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (exp_done.size() != 0 && i < 400) begin
            @(posedge clk);
            i++;
        end
        if (exp_done.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_done.delete();
            exp_acc.delete();
        end else begin
            check("acc_all_seen", exp_acc.size(), 0);
        end
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < WORDS; k++) l[k*WORD_W +: WORD_W] = $urandom;
        return l;
    endfunction

    initial begin
        logic [LINE_W-1:0] line_a;
        logic [LINE_W-1:0] line_c;
        logic [ADDR_W-1:0] base;
        int t0;

        rst_n           = 1'b0;
        bus.i_trigger   = 1'b0;
        bus.i_mode      = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_words = '0;
        bus.i_wrdata    = '0;
        ref_rddata      = '0;
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = WORD_W'(i * 4);
        for (int k = 0; k < WORDS; k++) line_a[k*WORD_W +: WORD_W] = 32'hA500_0000 + WORD_W'(k);

        repeat (3) @(posedge clk); #1;
        check("reset_ctrl", {bus.o_busy, bus.o_done, bus.o_err, bus.o_bram_en, bus.o_bram_we,
                             bus.o_bram_addr, bus.o_bram_wrdata}, '0);
        check("reset_rddata", bus.o_rddata, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed cases: full read, full write, partial read, wrap+clamp, unaligned.
        start_op(1'b1, 15'h0040, 0, '0);           wait_done();
        start_op(1'b0, 15'h0040, 0, line_a);       wait_done();
        start_op(1'b1, 15'h0100, 3, '0);           wait_done();
        start_op(1'b0, 15'h7FF8, 20, rand_line()); wait_done();
        start_op(1'b0, 15'h0042, 0, line_a);       wait_done();
        start_op(1'b1, 15'h0042, 0, '0);           wait_done();

        // Second trigger edge during a full write must be dropped.
        start_op(1'b0, 15'h0200, 0, rand_line());
        repeat (2) @(posedge clk); #1;
        bus.i_mode    = 1'b1;
        bus.i_trigger = 1'b1;
        @(posedge clk); #1;
        bus.i_trigger = 1'b0;
        wait_done();

        // Reset after word 5 of a full write, then a fresh full write.
        line_c = rand_line();
        start_op(1'b0, 15'h0400, 0, line_c);
        t0 = cyc - 1;
        while (cyc < t0 + 6) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {bus.o_busy, bus.o_done, bus.o_err, bus.o_bram_en, bus.o_bram_we,
                              bus.o_bram_addr, bus.o_bram_wrdata}, '0);
        check("midrst_rddata", bus.o_rddata, '0);
        exp_acc.delete();
        exp_done.delete();
        ref_rddata = '0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        start_op(1'b0, 15'h0400, 0, line_c); wait_done();

        // Read back the wrapped and reset-test regions.
        start_op(1'b1, 15'h7FF8, 0, '0); wait_done();
        start_op(1'b1, 15'h0400, 0, '0); wait_done();

        // Randomized mix of reads and writes over a small address window.
        for (int r = 0; r < 24; r++) begin
            base = ADDR_W'($urandom_range(0, 255)) * 4;
            if (r % 6 == 5) base[1:0] = 2'($urandom_range(1, 3));
            start_op(1'($urandom_range(0, 1)), base, $urandom_range(0, 31), rand_line());
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
